// File: rtl/alu.sv
// Registered 6-bit ALU feeding the board LED bank.
// MIPS funct-style opcodes; result lands one clock after the operands.
module alu #(
    parameter int N_BITS = 6,
    parameter int N_OP   = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_BITS-1:0] i_A,
    input  logic [N_BITS-1:0] i_B,
    input  logic [N_OP-1:0]   i_OP,
    output logic [N_BITS-1:0] o_led
);

    localparam logic [N_OP-1:0] OP_ADD = N_OP'(6'b100000);
    localparam logic [N_OP-1:0] OP_SUB = N_OP'(6'b100010);
    localparam logic [N_OP-1:0] OP_AND = N_OP'(6'b100100);
    localparam logic [N_OP-1:0] OP_OR  = N_OP'(6'b100101);
    localparam logic [N_OP-1:0] OP_XOR = N_OP'(6'b100110);
    localparam logic [N_OP-1:0] OP_NOR = N_OP'(6'b100111);
    localparam logic [N_OP-1:0] OP_SRA = N_OP'(6'b000011);
    localparam logic [N_OP-1:0] OP_SRL = N_OP'(6'b000010);

    localparam logic [N_BITS:0] SH_LIM = (N_BITS + 1)'(N_BITS);

    logic              sh_big;
    logic              msb;
    logic [N_BITS-1:0] sra_res;
    logic [N_BITS-1:0] srl_res;
    logic [N_BITS-1:0] nxt;

    // Oversized shift amounts saturate explicitly rather than
    // relying on the shifter's behaviour past the word width.
    assign sh_big = ({1'b0, i_B} >= SH_LIM);
    assign msb    = i_A[N_BITS-1];

    always_comb begin
        sra_res = '0;
        srl_res = '0;
        if (sh_big) begin
            sra_res = {N_BITS{msb}};
            srl_res = '0;
        end else begin
            sra_res = $unsigned($signed(i_A) >>> i_B);
            srl_res = i_A >> i_B;
        end
    end

    always_comb begin
        nxt = '0;
        case (i_OP)
            OP_ADD:  nxt = i_A + i_B;
            OP_SUB:  nxt = i_A - i_B;
            OP_AND:  nxt = i_A & i_B;
            OP_OR:   nxt = i_A | i_B;
            OP_XOR:  nxt = i_A ^ i_B;
            OP_NOR:  nxt = ~(i_A | i_B);
            OP_SRA:  nxt = sra_res;
            OP_SRL:  nxt = srl_res;
            default: nxt = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            o_led <= '0;
        else
            o_led <= nxt;
    end

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: reset, every opcode, wrap-around,
// shift saturation, illegal opcodes and async reset.
module tb_alu;

    logic       clock;
    logic       reset;
    logic [5:0] i_A;
    logic [5:0] i_B;
    logic [5:0] i_OP;
    logic [5:0] o_led;

    int total;
    int bad;

    localparam logic [5:0] ADD = 6'b100000;
    localparam logic [5:0] SUB = 6'b100010;
    localparam logic [5:0] AND = 6'b100100;
    localparam logic [5:0] OR  = 6'b100101;
    localparam logic [5:0] XOR = 6'b100110;
    localparam logic [5:0] NOR = 6'b100111;
    localparam logic [5:0] SRA = 6'b000011;
    localparam logic [5:0] SRL = 6'b000010;

    alu #(.N_BITS(6), .N_OP(6)) dut (
        .clock (clock),
        .reset (reset),
        .i_A   (i_A),
        .i_B   (i_B),
        .i_OP  (i_OP),
        .o_led (o_led)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag,
                       input logic [5:0] got,
                       input logic [5:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic op(input string tag, input logic [5:0] o,
                      input logic [5:0] a, input logic [5:0] b,
                      input logic [5:0] exp);
        @(negedge clock);
        i_OP = o;
        i_A  = a;
        i_B  = b;
        #1;
        // Before the edge the old result must still be held.
        @(posedge clock);
        #1;
        chk(tag, o_led, exp);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        i_A   = 6'd2;
        i_B   = 6'd3;
        i_OP  = ADD;

        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            chk("reset_hold", o_led, 6'd0);
        end

        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("release_pre", o_led, 6'd0);
        @(posedge clock);
        #1;
        chk("release", o_led, 6'd5);

        op("add",      ADD, 6'd2,  6'd3, 6'd5);
        op("sub",      SUB, 6'd6,  6'd5, 6'd1);
        op("and",      AND, 6'd5,  6'd5, 6'd5);
        op("or",       OR,  6'd5,  6'd2, 6'd7);

        // Inputs changing mid-cycle must not reach o_led.
        @(negedge clock);
        i_OP = ADD;
        i_A  = 6'd10;
        i_B  = 6'd10;
        #2;
        chk("hold_mid", o_led, 6'd7);

        op("sub_wrap", SUB, 6'd2,  6'd3, 6'd63);
        op("add_wrap", ADD, 6'd63, 6'd1, 6'd0);
        op("add_40",   ADD, 6'd40, 6'd40, 6'd16);
        op("xor",      XOR, 6'd5,  6'd3, 6'd6);
        op("nor",      NOR, 6'd5,  6'd2, 6'd56);
        op("nor_0",    NOR, 6'd0,  6'd0, 6'd63);
        op("sra",      SRA, 6'd32, 6'd2, 6'd56);
        op("srl",      SRL, 6'd32, 6'd2, 6'd8);
        op("sra_big",  SRA, 6'd32, 6'd9, 6'd63);
        op("srl_big",  SRL, 6'd63, 6'd6, 6'd0);
        op("sra_pos",  SRA, 6'd31, 6'd1, 6'd15);
        op("sra_5",    SRA, 6'd32, 6'd5, 6'd63);
        op("srl_5",    SRL, 6'd63, 6'd5, 6'd1);
        op("sra_0",    SRA, 6'd42, 6'd0, 6'd42);

        op("pre_ill0", OR,  6'd7,  6'd7, 6'd7);
        op("ill_00",   6'b000000, 6'd7, 6'd7, 6'd0);
        op("pre_ill3", OR,  6'd7,  6'd7, 6'd7);
        op("ill_3f",   6'b111111, 6'd7, 6'd7, 6'd0);
        op("pre_ill1", OR,  6'd7,  6'd7, 6'd7);
        op("ill_21",   6'b100001, 6'd7, 6'd7, 6'd0);

        op("pre_arst", ADD, 6'd5,  6'd2, 6'd7);
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_now", o_led, 6'd0);
        @(posedge clock);
        #1;
        chk("arst_hold", o_led, 6'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("arst_rel", o_led, 6'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
